// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, LSB first, with a start/busy/done handshake.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN (adds the i_sub port).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  // Subtraction is a + ~b + 1, so the same cell serves both operations.
`ifdef SERIAL_ADD_SUB_EN
  assign w_b_load = i_sub ? ~i_b : i_b;
  assign w_c_load = i_sub | i_cin;
`else
  assign w_b_load = i_b;
  assign w_c_load = i_cin;
`endif

  assign w_s        = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_c        = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);
  assign w_res_next = {w_s, r_res_sh[WIDTH-1:1]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_sum    <= '0;
      o_cout   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_a_sh   <= i_a;
            r_b_sh   <= w_b_load;
            r_carry  <= w_c_load;
            r_res_sh <= '0;
            r_cnt    <= '0;
            o_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_carry  <= w_c;
          r_res_sh <= w_res_next;
          r_cnt    <= r_cnt + 1'b1;
          // Last bit: publish the whole result at once so sum is never partial.
          if (r_cnt == LAST_CNT) begin
            o_sum   <= w_res_next;
            o_cout  <= w_c;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
